// File: rtl/ls161_sync_counter_if.sv
// Parallel-load / enable / status bundle of one ls161_sync_counter stage.
// The master drives load and enable controls plus load data; the slave
// (the counter) returns its state and ripple carry.
interface ls161_sync_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load_n;
  logic             enp;
  logic             ent;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             rco;

  modport master (
    output load_n, enp, ent, d,
    input  q, rco
  );

  modport slave (
    input  load_n, enp, ent, d,
    output q, rco
  );
endinterface

// File: rtl/ls161_sync_counter.sv
// 74LS161-style synchronous presettable counter: async clear, sync load,
// ENP/ENT count enables, ENT-gated ripple carry for cascading stages.
// Optional macro COUNTER_MODULO_EN adds parameter MODULO and makes the
// count wrap from MODULO-1 to 0 (decade / sexagesimal digits).
// DELAY is kept for parity with the gate library; the synthesizable model
// is zero-delay.
module ls161_sync_counter #(
  parameter int          DELAY  = 10,
  parameter int unsigned WIDTH  = 4
`ifdef COUNTER_MODULO_EN
  ,
  parameter int unsigned MODULO = 10
`endif
) (
  input logic                clk,
  input logic                clr_n,
  ls161_sync_counter_if.slave bus
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1 || WIDTH > 8) begin : g_bad_width
    $error("ls161_sync_counter: WIDTH must be 1..8");
  end
  if (DELAY < 0) begin : g_bad_delay
    $error("ls161_sync_counter: DELAY must be non-negative");
  end

`ifdef COUNTER_MODULO_EN
  if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
    $error("ls161_sync_counter: MODULO must be 2..2**WIDTH");
  end
  // Terminal count: last state before the modulo wrap.
  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULO - 1);
`else
  localparam logic [WIDTH-1:0] TERM = {WIDTH{1'b1}};
`endif

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;

  // Next state: load beats count; count wraps at TERM. A loaded value past
  // TERM counts up in binary and falls back to 0 at the natural overflow.
  always_comb begin
    q_nxt = q_r;
    if (!bus.load_n) begin
      q_nxt = bus.d;
    end else if (bus.enp && bus.ent) begin
      if (q_r == TERM) begin
        q_nxt = '0;
      end else begin
        q_nxt = q_r + WIDTH'(1);
      end
    end
  end

  // Counter state register; clear is asynchronous and overrides the clock.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_r <= '0;
    end else begin
      q_r <= q_nxt;
    end
  end

  assign bus.q   = q_r;
  // Ripple carry follows live ent so a cascade can stall the upper stage.
  assign bus.rco = bus.ent & (q_r == TERM);

endmodule

// File: tb/tb_ls161_sync_counter.sv
// Self-checking bench for ls161_sync_counter: directed scenarios plus a
// randomized run against an arithmetic reference model; two cascaded stages.
module tb_ls161_sync_counter;

  localparam int unsigned WIDTH = 4;
`ifdef COUNTER_MODULO_EN
  localparam int MODV = 10;
`else
  localparam int MODV = 16;
`endif

  logic       clk = 1'b0;
  logic       clr_n;
  logic       load_n;
  logic       enp;
  logic       ent;
  logic [3:0] d;
  logic       hi_load_n;
  logic [3:0] hi_d;

  int checks = 0;
  int errors = 0;
  logic [3:0] ref_q;

  ls161_sync_counter_if #(.WIDTH(WIDTH)) bus_lo ();
  ls161_sync_counter_if #(.WIDTH(WIDTH)) bus_hi ();

  assign bus_lo.load_n = load_n;
  assign bus_lo.enp    = enp;
  assign bus_lo.ent    = ent;
  assign bus_lo.d      = d;
  assign bus_hi.load_n = hi_load_n;
  assign bus_hi.enp    = enp;
  assign bus_hi.ent    = bus_lo.rco;
  assign bus_hi.d      = hi_d;

  ls161_sync_counter #(.DELAY(10), .WIDTH(WIDTH)) u_lo (
    .clk(clk), .clr_n(clr_n), .bus(bus_lo.slave)
  );
  ls161_sync_counter #(.DELAY(10), .WIDTH(WIDTH)) u_hi (
    .clk(clk), .clr_n(clr_n), .bus(bus_hi.slave)
  );

  always #5 clk = ~clk;

  // Reference: next value from the counting rules expressed arithmetically.
  function automatic logic [3:0] model_next(input logic [3:0] q, input logic ld_n,
                                            input logic p, input logic t,
                                            input logic [3:0] dd);
    if (!ld_n) return dd;
    if (!(p && t)) return q;
    if (int'(q) == MODV - 1) return 4'd0;
    return 4'((int'(q) + 1) % 16);
  endfunction

  function automatic logic model_rco(input logic [3:0] q, input logic t);
    return t && (int'(q) == MODV - 1);
  endfunction

  // One rising edge: advance the model, then settle past the edge.
  task automatic tick();
    @(posedge clk);
    if (clr_n) ref_q = model_next(ref_q, load_n, enp, ent, d);
    else       ref_q = 4'd0;
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; load_n = 1'b1; enp = 1'b0; ent = 1'b1; d = 4'd0;
    hi_load_n = 1'b1; hi_d = 4'd0; ref_q = 4'd0;
    tick(); tick();
    checks++;
    if (bus_lo.q !== 4'd0 || bus_lo.rco !== 1'b0) begin
      errors++;
      $display("FAIL reset_init q=%h rco=%b required q=0 rco=0", bus_lo.q, bus_lo.rco);
    end
    clr_n = 1'b1;
    load_n = 1'b0; d = 4'h7;
    tick();
    load_n = 1'b1;
    checks++;
    if (bus_lo.q !== 4'h7) begin
      errors++;
      $display("FAIL reset_preload q=%h required 7", bus_lo.q);
    end
    #3 clr_n = 1'b0;
    #1;
    checks++;
    if (bus_lo.q !== 4'd0 || bus_lo.rco !== 1'b0) begin
      errors++;
      $display("FAIL reset_async q=%h rco=%b required q=0 rco=0", bus_lo.q, bus_lo.rco);
    end
    enp = 1'b1; ent = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus_lo.q !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold edge=%0d q=%h required 0", i, bus_lo.q);
      end
    end
    clr_n = 1'b1;
    ref_q = 4'd0;
  endtask

  task automatic test_count_wrap();
    logic [3:0] exp_q;
    load_n = 1'b1; enp = 1'b1; ent = 1'b1;
    for (int i = 1; i <= MODV + 1; i++) begin
      tick();
      exp_q = 4'(i % MODV);
      checks++;
      if (bus_lo.q !== exp_q || bus_lo.rco !== (int'(exp_q) == MODV - 1)) begin
        errors++;
        $display("FAIL count_wrap edge=%0d q=%h rco=%b required q=%h rco=%b",
                 i, bus_lo.q, bus_lo.rco, exp_q, int'(exp_q) == MODV - 1);
      end
    end
  endtask

  task automatic test_load_priority();
    load_n = 1'b0; d = 4'h3; enp = 1'b0;
    tick();
    d = 4'hC; enp = 1'b1; ent = 1'b1;
    tick();
    checks++;
    if (bus_lo.q !== 4'hC) begin
      errors++;
      $display("FAIL load_priority q=%h required C", bus_lo.q);
    end
    d = 4'hF;
    tick();
    load_n = 1'b1; enp = 1'b0;
    #1;
    checks++;
    if (bus_lo.q !== 4'hF || bus_lo.rco !== (MODV == 16)) begin
      errors++;
      $display("FAIL load_all_ones q=%h rco=%b required q=F rco=%b",
               bus_lo.q, bus_lo.rco, MODV == 16);
    end
  endtask

  task automatic test_enable_gating();
    enp = 1'b0; ent = 1'b1; load_n = 1'b1;
    tick();
    checks++;
    if (bus_lo.q !== 4'hF || bus_lo.rco !== (MODV == 16)) begin
      errors++;
      $display("FAIL enp_hold q=%h rco=%b required q=F rco=%b",
               bus_lo.q, bus_lo.rco, MODV == 16);
    end
    ent = 1'b0;
    #1;
    checks++;
    if (bus_lo.rco !== 1'b0) begin
      errors++;
      $display("FAIL ent_gate_rco rco=%b required 0", bus_lo.rco);
    end
    enp = 1'b1;
    tick();
    checks++;
    if (bus_lo.q !== 4'hF || bus_lo.rco !== 1'b0) begin
      errors++;
      $display("FAIL ent_hold q=%h rco=%b required q=F rco=0", bus_lo.q, bus_lo.rco);
    end
  endtask

  task automatic test_cascade();
    logic [3:0] exp_lo, exp_hi;
    logic       nand_out, exp_nand;
    #2 clr_n = 1'b0;
    #1 clr_n = 1'b1;
    ref_q = 4'd0;
    load_n = 1'b1; hi_load_n = 1'b1; enp = 1'b1; ent = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      tick();
      exp_lo   = 4'(n % MODV);
      exp_hi   = 4'((n / MODV) % MODV);
      exp_nand = !((n % 256) == 255 && MODV == 16);
      nand_out = ~&{bus_hi.q, bus_lo.q};
      checks++;
      if (bus_lo.q !== exp_lo || bus_hi.q !== exp_hi || nand_out !== exp_nand) begin
        errors++;
        $display("FAIL cascade n=%0d got=%h%h nand=%b required=%h%h nand=%b",
                 n, bus_hi.q, bus_lo.q, nand_out, exp_hi, exp_lo, exp_nand);
      end
    end
  endtask

`ifdef COUNTER_MODULO_EN
  task automatic test_modulo_overload();
    logic [3:0] seq [5];
    seq[0] = 4'hC; seq[1] = 4'hD; seq[2] = 4'hE; seq[3] = 4'hF; seq[4] = 4'h0;
    load_n = 1'b0; d = 4'hC; enp = 1'b1; ent = 1'b1;
    tick();
    load_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus_lo.q !== seq[i] || bus_lo.rco !== 1'b0) begin
        errors++;
        $display("FAIL modulo_overload step=%0d q=%h rco=%b required q=%h rco=0",
                 i, bus_lo.q, bus_lo.rco, seq[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load_n = ($urandom_range(0, 3) != 0);
      enp    = ($urandom_range(0, 3) != 0);
      ent    = ($urandom_range(0, 3) != 0);
      d      = 4'($urandom);
      #1;
      checks++;
      if (bus_lo.rco !== model_rco(ref_q, ent)) begin
        errors++;
        $display("FAIL random_rco_live i=%0d rco=%b required %b", i, bus_lo.rco,
                 model_rco(ref_q, ent));
      end
      tick();
      checks++;
      if (bus_lo.q !== ref_q || bus_lo.rco !== model_rco(ref_q, ent)) begin
        errors++;
        $display("FAIL random i=%0d q=%h rco=%b required q=%h rco=%b",
                 i, bus_lo.q, bus_lo.rco, ref_q, model_rco(ref_q, ent));
      end
      if ($urandom_range(0, 31) == 0) begin
        #1 clr_n = 1'b0;
        #1;
        ref_q = 4'd0;
        checks++;
        if (bus_lo.q !== 4'd0 || bus_lo.rco !== 1'b0) begin
          errors++;
          $display("FAIL random_clear i=%0d q=%h rco=%b required q=0 rco=0",
                   i, bus_lo.q, bus_lo.rco);
        end
        clr_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_load_priority();
    test_enable_gating();
    test_cascade();
`ifdef COUNTER_MODULO_EN
    test_modulo_overload();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
